// File: rtl/video_pkg.sv
// Shared defaults for the 640x480@60 timing set, sync polarity constants and a
// constant-evaluable clog2 used to size the position counters.
package video_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_SCALE_SH = 1;
  localparam int unsigned DEF_ADDR_W   = 17;

  localparam bit ACTIVE_LOW  = 1'b0;
  localparam bit ACTIVE_HIGH = 1'b1;

  // Bits needed to hold 0..value-1; never less than 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 1;
    while ((64'd1 << width) < 64'(value)) begin
      width++;
    end
    return width;
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Video timing bundle: control inputs into the generator and the timing,
// position, read-address and bank outputs consumed by pixel-fetch/draw logic.
interface video_timing_gen_if
  import video_pkg::*;
#(
  parameter int unsigned X_W    = clog2(DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP),
  parameter int unsigned Y_W    = clog2(DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP),
  parameter int unsigned ADDR_W = DEF_ADDR_W
);

  logic              en;
  logic              swap_req;
  logic              hsync;
  logic              vsync;
  logic              de;
  logic [X_W-1:0]    xpos;
  logic [Y_W-1:0]    ypos;
  logic              line_start;
  logic              frame_start;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic              bank_sel;
  logic              swap_ack;

  modport master (
    input  en, swap_req,
    output hsync, vsync, de, xpos, ypos, line_start, frame_start,
    output rd_addr, rd_valid, bank_sel, swap_ack
  );

  modport slave (
    output en, swap_req,
    input  hsync, vsync, de, xpos, ypos, line_start, frame_start,
    input  rd_addr, rd_valid, bank_sel, swap_ack
  );

endinterface

// File: rtl/video_axis_cnt.sv
// One timing axis: wrapping position counter with active/sync decode. Used once
// per pixel for the horizontal axis and once per line for the vertical axis.
module video_axis_cnt
  import video_pkg::*;
#(
  parameter int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned FP     = DEF_H_FP,
  parameter int unsigned SYNC   = DEF_H_SYNC,
  parameter int unsigned BP     = DEF_H_BP,
  parameter bit          POL    = ACTIVE_LOW
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   inc,
  input  logic                                   clr,
  output logic [clog2(ACTIVE+FP+SYNC+BP)-1:0]    count,
  output logic [clog2(ACTIVE+FP+SYNC+BP)-1:0]    count_nxt,
  output logic                                   active,
  output logic                                   active_nxt,
  output logic                                   sync,
  output logic                                   wrap
);

  localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;
  localparam int unsigned CNT_W = clog2(TOTAL);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = wrap ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count      = count_q;
  assign count_nxt  = count_d;
  assign wrap       = (count_q == CNT_W'(TOTAL - 1));
  assign active     = (count_q < CNT_W'(ACTIVE));
  assign active_nxt = (count_d < CNT_W'(ACTIVE));
  // Sync level already carries the configured polarity.
  assign sync = ((count_q >= CNT_W'(ACTIVE + FP)) && (count_q < CNT_W'(ACTIVE + FP + SYNC)))
                ? POL : ~POL;

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator with downscaled frame-buffer read
// addressing and frame-synchronous ping-pong bank selection.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          HS_POL   = ACTIVE_LOW,
  parameter bit          VS_POL   = ACTIVE_LOW,
  parameter int unsigned SCALE_SH = DEF_SCALE_SH,
  parameter int unsigned ADDR_W   = DEF_ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  video_timing_gen_if.master vid
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned X_W      = clog2(H_TOTAL);
  localparam int unsigned Y_W      = clog2(V_TOTAL);
  localparam int unsigned BUF_W    = H_ACTIVE >> SCALE_SH;
  localparam int unsigned BUF_H    = V_ACTIVE >> SCALE_SH;
  localparam int unsigned SUB_MASK = (1 << SCALE_SH) - 1;

  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_timing
    $error("video_timing_gen: timing parameters must all be non-zero");
  end

  if (64'(BUF_W) * 64'(BUF_H) > (64'd1 << ADDR_W)) begin : g_bad_buffer
    $error("video_timing_gen: downscaled buffer does not fit in ADDR_W bits");
  end

  logic [X_W-1:0] h_cnt, h_nxt;
  logic [Y_W-1:0] v_cnt, v_nxt;
  logic           h_act, h_act_nxt, h_sync, h_wrap;
  logic           v_act, v_act_nxt, v_sync, v_wrap;

  video_axis_cnt #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HS_POL)
  ) u_h_axis (
    .clk        (clk),
    .rst        (rst),
    .inc        (vid.en),
    .clr        (!vid.en),
    .count      (h_cnt),
    .count_nxt  (h_nxt),
    .active     (h_act),
    .active_nxt (h_act_nxt),
    .sync       (h_sync),
    .wrap       (h_wrap)
  );

  video_axis_cnt #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VS_POL)
  ) u_v_axis (
    .clk        (clk),
    .rst        (rst),
    .inc        (vid.en && h_wrap),
    .clr        (!vid.en),
    .count      (v_cnt),
    .count_nxt  (v_nxt),
    .active     (v_act),
    .active_nxt (v_act_nxt),
    .sync       (v_sync),
    .wrap       (v_wrap)
  );

  logic              de_q, de_d;
  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;
  logic              line_start_q, line_start_d;
  logic              frame_start_q, frame_start_d;
  logic [X_W-1:0]    xpos_q;
  logic [Y_W-1:0]    ypos_q;
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_valid_q, rd_valid_d;
  logic              pending_q, pending_d;
  logic              bank_q, bank_d;
  logic              ack_q, ack_d;
  logic              boundary;

  // Timing outputs decode the current counters and land one clock later.
  always_comb begin
    de_d          = vid.en && h_act && v_act;
    hsync_d       = vid.en ? h_sync : ~HS_POL;
    vsync_d       = vid.en ? v_sync : ~VS_POL;
    line_start_d  = vid.en && (h_cnt == '0);
    frame_start_d = line_start_d && (v_cnt == '0);
  end

  // Read side decodes the next counter values, so it runs one pixel ahead of de.
  // The column term is the counter's upper bits: it steps once per 2^SCALE_SH pixels.
  always_comb begin
    line_base_d = line_base_q;
    if (!vid.en || (h_wrap && v_wrap)) begin
      line_base_d = '0;
    end else if (h_wrap && v_act_nxt && ((32'(v_nxt) & SUB_MASK) == 0)) begin
      line_base_d = line_base_q + ADDR_W'(BUF_W);
    end
    rd_valid_d = h_act_nxt && v_act_nxt;
    rd_addr_d  = rd_addr_q;
    if (rd_valid_d) begin
      rd_addr_d = line_base_d + ADDR_W'(h_nxt >> SCALE_SH);
    end
  end

  // A request coincident with the boundary is folded in before the swap decision.
  always_comb begin
    boundary  = vid.en && h_wrap && v_wrap;
    pending_d = pending_q || vid.swap_req;
    bank_d    = bank_q;
    ack_d     = 1'b0;
    if (boundary && pending_d) begin
      bank_d    = ~bank_q;
      ack_d     = 1'b1;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_q          <= 1'b0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      xpos_q        <= '0;
      ypos_q        <= '0;
      line_base_q   <= '0;
      rd_addr_q     <= '0;
      rd_valid_q    <= 1'b0;
      pending_q     <= 1'b0;
      bank_q        <= 1'b0;
      ack_q         <= 1'b0;
    end else begin
      de_q          <= de_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      xpos_q        <= h_cnt;
      ypos_q        <= v_cnt;
      line_base_q   <= line_base_d;
      rd_addr_q     <= rd_addr_d;
      rd_valid_q    <= rd_valid_d;
      pending_q     <= pending_d;
      bank_q        <= bank_d;
      ack_q         <= ack_d;
    end
  end

  assign vid.de          = de_q;
  assign vid.hsync       = hsync_q;
  assign vid.vsync       = vsync_q;
  assign vid.line_start  = line_start_q;
  assign vid.frame_start = frame_start_q;
  assign vid.xpos        = xpos_q;
  assign vid.ypos        = ypos_q;
  assign vid.rd_addr     = rd_addr_q;
  // Gated by en so the read strobe drops in the same cycle timing is halted.
  assign vid.rd_valid    = rd_valid_q && vid.en;
  assign vid.bank_sel    = bank_q;
  assign vid.swap_ack    = ack_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a 14x7 raster: one unscaled active-low
// instance and one 2x-downscaled active-high instance running in lockstep.
module tb_video_timing_gen;
  import video_pkg::*;

  localparam int unsigned HT    = 14;
  localparam int unsigned VT    = 7;
  localparam int unsigned FRAME = 98;
  localparam int unsigned XW    = clog2(HT);
  localparam int unsigned YW    = clog2(VT);
  localparam int unsigned AW    = 8;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  video_timing_gen_if #(.X_W(XW), .Y_W(YW), .ADDR_W(AW)) vid0 ();
  video_timing_gen_if #(.X_W(XW), .Y_W(YW), .ADDR_W(AW)) vid1 ();

  video_timing_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .HS_POL   (ACTIVE_LOW), .VS_POL (ACTIVE_LOW),
    .SCALE_SH (0), .ADDR_W (AW)
  ) dut0 (
    .clk (clk),
    .rst (rst),
    .vid (vid0)
  );

  video_timing_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .HS_POL   (ACTIVE_HIGH), .VS_POL (ACTIVE_HIGH),
    .SCALE_SH (1), .ADDR_W (AW)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .vid (vid1)
  );

  task automatic set_en(input logic v);
    vid0.en = v;
    vid1.en = v;
  endtask

  task automatic set_swap(input logic v);
    vid0.swap_req = v;
    vid1.swap_req = v;
  endtask

  // Leaves the bench on the negedge where frame_start (pixel 0,0) is visible.
  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (vid0.frame_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_total++;
    if (!ok) $display("FAIL frame_sync: frame_start=%b, required 1 within 300 clocks",
                      vid0.frame_start);
    else n_pass++;
  endtask

  task automatic test_reset;
    logic [6:0] got;
    set_en(1'b1);
    set_swap(1'b0);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    // de, hsync, vsync, bank_sel, swap_ack, frame_start, line_start
    got = {vid0.de, vid0.hsync, vid0.vsync, vid0.bank_sel, vid0.swap_ack,
           vid0.frame_start, vid0.line_start};
    n_total++;
    if (got !== 7'b0110000) $display("FAIL reset_dut0: got %b required 0110000", got);
    else n_pass++;
    got = {vid1.de, vid1.hsync, vid1.vsync, vid1.bank_sel, vid1.swap_ack,
           vid1.frame_start, vid1.rd_valid};
    n_total++;
    if (got !== 7'b0000000) $display("FAIL reset_dut1: got %b required 0000000", got);
    else n_pass++;
    n_total++;
    if ({vid0.rd_addr, vid0.xpos, vid0.ypos} !== '0)
      $display("FAIL reset_pos: rd_addr=%0d xpos=%0d ypos=%0d required 0/0/0",
               vid0.rd_addr, vid0.xpos, vid0.ypos);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    got = {vid0.de, vid0.line_start, vid0.frame_start, 4'b0000};
    n_total++;
    if (got !== 7'b1110000 || vid0.xpos !== '0 || vid0.ypos !== '0)
      $display("FAIL first_pixel: de/ls/fs got %b xpos=%0d ypos=%0d required 111 0 0",
               got[6:4], vid0.xpos, vid0.ypos);
    else n_pass++;
  endtask

  task automatic test_timing;
    bit             ok;
    int             h, v, ph, pv;
    logic [4:0]     got, exp;
    logic           exp_valid;
    logic [AW-1:0]  exp_addr;
    wait_frame(ok);
    for (int k = 0; k <= int'(FRAME); k++) begin
      if (k > 0) @(negedge clk);
      h  = k % HT;
      v  = (k / HT) % VT;
      ph = (k + 1) % HT;
      pv = ((k + 1) / HT) % VT;
      exp = {(h < 8) && (v < 4), !(h == 10 || h == 11), v != 5, h == 0, (h == 0) && (v == 0)};
      got = {vid0.de, vid0.hsync, vid0.vsync, vid0.line_start, vid0.frame_start};
      n_total++;
      if (got !== exp) $display("FAIL timing k=%0d: de/hs/vs/ls/fs got %b required %b",
                                k, got, exp);
      else n_pass++;
      n_total++;
      if (vid0.xpos !== XW'(h) || vid0.ypos !== YW'(v))
        $display("FAIL pos k=%0d: xpos=%0d ypos=%0d required %0d %0d",
                 k, vid0.xpos, vid0.ypos, h, v);
      else n_pass++;
      exp_valid = (ph < 8) && (pv < 4);
      exp_addr  = AW'(pv * 8 + ph);
      n_total++;
      if (vid0.rd_valid !== exp_valid || (exp_valid && vid0.rd_addr !== exp_addr))
        $display("FAIL rd_unscaled k=%0d: valid=%b addr=%0d required %b %0d",
                 k, vid0.rd_valid, vid0.rd_addr, exp_valid, exp_addr);
      else n_pass++;
    end
  endtask

  task automatic test_rd_addr;
    bit             ok;
    int             h, v, ph, pv;
    logic [3:0]     got, exp;
    logic [AW-1:0]  exp_addr;
    exp_addr = '0;
    wait_frame(ok);
    for (int k = 0; k < int'(FRAME); k++) begin
      if (k > 0) @(negedge clk);
      h  = k % HT;
      v  = k / HT;
      ph = (k + 1) % HT;
      pv = ((k + 1) / HT) % VT;
      if (ph < 8 && pv < 4) exp_addr = AW'((pv / 2) * 4 + ph / 2);
      // rd_valid, de, hsync, vsync (active-high on this instance)
      exp = {(ph < 8) && (pv < 4), (h < 8) && (v < 4), h == 10 || h == 11, v == 5};
      got = {vid1.rd_valid, vid1.de, vid1.hsync, vid1.vsync};
      n_total++;
      if (got !== exp) $display("FAIL scaled_timing k=%0d: rv/de/hs/vs got %b required %b",
                                k, got, exp);
      else n_pass++;
      n_total++;
      if (vid1.rd_addr !== exp_addr)
        $display("FAIL rd_addr k=%0d: got %0d required %0d", k, vid1.rd_addr, exp_addr);
      else n_pass++;
    end
  endtask

  task automatic test_swap;
    bit         ok;
    logic [3:0] got, exp;
    wait_frame(ok);
    for (int k = 0; k < 2 * int'(FRAME); k++) begin
      if (k > 0) @(negedge clk);
      set_swap(k == 30 || k == 45 || k == 60);
      exp = {k >= 97, k == 97, k >= 97, k == 97};
      got = {vid0.bank_sel, vid0.swap_ack, vid1.bank_sel, vid1.swap_ack};
      n_total++;
      if (got !== exp) $display("FAIL swap k=%0d: bank/ack x2 got %b required %b", k, got, exp);
      else n_pass++;
    end
    set_swap(1'b0);
  endtask

  task automatic test_swap_boundary;
    bit         ok;
    logic [1:0] got, exp;
    wait_frame(ok);
    for (int k = 0; k <= 196; k++) begin
      if (k > 0) @(negedge clk);
      // Held over the boundary cycle and the following swap_ack cycle.
      set_swap(k == 96 || k == 97);
      exp = {(k < 97) || (k >= 195), k == 97 || k == 195};
      got = {vid0.bank_sel, vid0.swap_ack};
      n_total++;
      if (got !== exp) $display("FAIL swap_boundary k=%0d: bank/ack got %b required %b",
                                k, got, exp);
      else n_pass++;
    end
    set_swap(1'b0);
  endtask

  task automatic test_en_gap;
    bit         ok;
    logic [6:0] got;
    logic [4:0] got1;
    wait_frame(ok);
    repeat (18) @(negedge clk);
    set_en(1'b0);
    #1;
    n_total++;
    if ({vid0.rd_valid, vid1.rd_valid} !== 2'b00)
      $display("FAIL en_drop_rv: got %b required 00", {vid0.rd_valid, vid1.rd_valid});
    else n_pass++;
    for (int k = 19; k <= 38; k++) begin
      @(negedge clk);
      // de, rd_valid, hsync, vsync, line_start, frame_start, bank_sel
      got  = {vid0.de, vid0.rd_valid, vid0.hsync, vid0.vsync, vid0.line_start,
              vid0.frame_start, vid0.bank_sel};
      got1 = {vid1.de, vid1.rd_valid, vid1.hsync, vid1.vsync, vid1.bank_sel};
      n_total++;
      if (got !== 7'b0011001 || got1 !== 5'b00001)
        $display("FAIL en_idle k=%0d: dut0 %b required 0011001, dut1 %b required 00001",
                 k, got, got1);
      else n_pass++;
    end
    set_en(1'b1);
    #1;
    n_total++;
    if (vid0.rd_valid !== 1'b1 || vid0.rd_addr !== '0)
      $display("FAIL en_rise_rd: valid=%b addr=%0d required 1 0", vid0.rd_valid, vid0.rd_addr);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({vid0.frame_start, vid0.line_start, vid0.de} !== 3'b111 ||
        vid0.xpos !== '0 || vid0.ypos !== '0)
      $display("FAIL en_restart: fs/ls/de=%b xpos=%0d ypos=%0d required 111 0 0",
               {vid0.frame_start, vid0.line_start, vid0.de}, vid0.xpos, vid0.ypos);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (vid0.frame_start !== 1'b0 || vid0.xpos !== XW'(1) || vid0.de !== 1'b1)
      $display("FAIL en_second: fs=%b xpos=%0d de=%b required 0 1 1",
               vid0.frame_start, vid0.xpos, vid0.de);
    else n_pass++;
  endtask

  task automatic test_reset_async;
    bit         ok;
    logic [3:0] got;
    wait_frame(ok);
    repeat (16) @(negedge clk);
    n_total++;
    if (vid1.de !== 1'b1 || vid1.bank_sel !== 1'b1 || vid1.rd_addr !== AW'(1))
      $display("FAIL pre_reset: de=%b bank=%b addr=%0d required 1 1 1",
               vid1.de, vid1.bank_sel, vid1.rd_addr);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    got = {vid1.de, vid1.hsync, vid1.vsync, vid1.bank_sel};
    n_total++;
    if (got !== 4'b0000 || vid1.rd_addr !== '0)
      $display("FAIL async_reset_dut1: de/hs/vs/bank got %b addr=%0d required 0000 0",
               got, vid1.rd_addr);
    else n_pass++;
    got = {vid0.de, vid0.hsync, vid0.vsync, vid0.bank_sel};
    n_total++;
    if (got !== 4'b0110 || vid0.rd_addr !== '0)
      $display("FAIL async_reset_dut0: de/hs/vs/bank got %b addr=%0d required 0110 0",
               got, vid0.rd_addr);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b0;
    set_en(1'b1);
    set_swap(1'b0);
    test_reset();
    test_timing();
    test_rd_addr();
    test_swap();
    test_swap_boundary();
    test_en_gap();
    test_reset_async();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 h_sync/v_sync pair. One counter pair generates hsync, vsync and de for any resolution, with selectable sync polarity.
- Adds integer-downscaled frame-buffer read addressing, e.g. a 320x240 buffer shown at 640x480.
- Adds ping-pong bank selection that swaps only at frame boundaries, replacing the ad-hoc switch_ram/frame_sw_ram handling.
- Sits between the clock generator and the pixel-fetch/draw logic. It runs in the pixel-clock domain.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level
- SCALE_SH, 1, downscale shift; buffer is (H_ACTIVE>>SCALE_SH) x (V_ACTIVE>>SCALE_SH)
- ADDR_W, 17, read address width

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  timing enable (driven by I2C-config done); low holds the counters at origin
- swap_req  in  1  single-cycle pulse: writer finished the back bank
- hsync  out  1  horizontal sync, polarity set by HS_POL
- vsync  out  1  vertical sync, polarity set by VS_POL
- de  out  1  active video
- xpos  out  CLOG2(H_TOTAL)  current column, aligned with de
- ypos  out  CLOG2(V_TOTAL)  current line, aligned with de
- line_start  out  1  one-cycle pulse at h_cnt==0
- frame_start  out  1  one-cycle pulse at h_cnt==0 && v_cnt==0
- rd_addr  out  ADDR_W  buffer read address
- rd_valid  out  1  rd_addr is meaningful; leads de by exactly 1 clock
- bank_sel  out  1  bank currently displayed
- swap_ack  out  1  one-cycle pulse when bank_sel toggles

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Line order: active region first, then front porch, sync, back porch.
- h_cnt counts 0..H_TOTAL-1 and wraps to 0. v_cnt increments when h_cnt wraps and itself wraps at V_TOTAL-1.
- Registered outputs, 1 clock after the counters:
  - de = (h_cnt<H_ACTIVE) && (v_cnt<V_ACTIVE)
  - hsync is active while H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC
  - vsync is active on lines V_ACTIVE+V_FP .. V_ACTIVE+V_FP+V_SYNC-1, for whole lines
- xpos and ypos are the registered counters, so they are aligned with de.
- rd_valid and rd_addr are decoded from the counters one pixel ahead, so they lead de by 1 clock. Sync-RAM data then lands aligned with de.
- Address formula: rd_addr = (v>>SCALE_SH)*(H_ACTIVE>>SCALE_SH) + (h>>SCALE_SH). It is built incrementally, with no multiplier:
  - a line-base register adds the buffer width once per 2^SCALE_SH active lines;
  - a column counter steps once per 2^SCALE_SH pixels;
  - both reset to 0 at frame_start.
  - The sum is truncated to ADDR_W.
  - When rd_valid is low, rd_addr holds its last value.
- Swap logic:
  - A swap_req pulse sets a sticky pending bit.
  - At the frame boundary (h_cnt==H_TOTAL-1 && v_cnt==V_TOTAL-1 && en), if pending is set: bank_sel toggles, swap_ack pulses for 1 cycle, and pending clears.
  - A swap_req in the same cycle as the boundary is honoured at that boundary.
  - Further requests while pending is already set are merged.
  - A swap_req arriving during the swap_ack cycle sets pending for the next frame.
- en low:
  - the next clock forces h_cnt=v_cnt=0;
  - de, rd_valid, line_start and frame_start are 0; hsync and vsync are inactive;
  - pending and bank_sel are held.
  - On the rising edge of en, counting starts from the origin, and frame_start is issued 1 clock after the first enabled count-0 cycle.
- Reset (async, mid-frame allowed):
  - counters, pending, bank_sel, rd_addr, xpos, ypos and all pulses go to 0;
  - de = 0;
  - hsync = ~HS_POL, vsync = ~VS_POL (inactive).
- Parameter check: elaboration fails if any timing parameter is 0, or if the buffer size (H_ACTIVE>>SCALE_SH)*(V_ACTIVE>>SCALE_SH) exceeds 2^ADDR_W.

Decomposition:
- Shared package video_pkg:
  - default timing constants for the 640x480@60 set;
  - a CLOG2 function;
  - polarity constants ACTIVE_LOW and ACTIVE_HIGH.
- One natural sub-module, video_axis_cnt, instantiated twice (horizontal and vertical). Parameters ACTIVE, FP, SYNC, BP, POL. It has an increment-enable input and outputs count, active, sync and wrap.
- Address and swap logic stay in the top.

Test Plan:
- Small timing: H 8/2/2/2 (H_TOTAL 14), V 4/1/1/1 (V_TOTAL 7), SCALE_SH 0, en=1.
  - Required: de high for 8 clocks per line on lines 0-3.
  - hsync low on h_cnt 10-11; vsync low for all of line 5.
  - frame period 98 clocks.
- Same timing with SCALE_SH=1.
  - Required: rd_addr sequence per line 0,0,1,1,2,2,3,3.
  - Lines 0-1 use base 0, lines 2-3 use base 4.
  - rd_valid rises exactly 1 clock before de.
- swap_req pulse at line 2.
  - Required: bank_sel toggles 1->0 or 0->1 only at the frame boundary, with swap_ack high for 1 clock.
  - Two more pulses in the same frame cause a single toggle.
- swap_req coincident with the boundary cycle.
  - Required: the toggle happens at that boundary, not one frame later.
- en deasserted at h_cnt 5, line 1, then reasserted after 20 clocks.
  - Required: outputs idle and inactive during the gap; bank_sel unchanged.
  - frame_start is seen 1 clock after the first enabled count-0 cycle, with xpos=0, ypos=0.
- rst asserted mid-active-line with HS_POL=1.
  - Required, immediately and asynchronously: de=0, hsync=0, vsync=0, bank_sel=0, rd_addr=0.
